vec_mem_arbiter: RTL and testbench
==================================

Name: vec_mem_arbiter

Overview:
- Shared vector-memory server sitting directly downstream of the compute units' memory interfaces.
- Arbitrates round-robin among NUM_UNITS requesters and owns a VEC_ENTRIES-deep vector register file.
- Services load, store and compute-operand-fetch operations; returns mem_grant, read_data and a one-cycle mem_done to the winning unit.

Parameters:
- NUM_UNITS, 4, number of requesting units; index width 2.
- VEC_ENTRIES, 16, vector register file depth; 16 or fewer.
- MEM_LATENCY, 2, ACCESS-state cycles per transaction; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_request  in  NUM_UNITS  per-unit request, held until that unit's mem_done
- mem_op_type  in  NUM_UNITS x 4  per-unit op: 0001 load, 0010 store, 0100 compute fetch
- vec_index  in  NUM_UNITS x 4  per-unit entry address
- write_data  in  NUM_UNITS x vector_data_t  per-unit store data
- mem_grant  out  NUM_UNITS  one-hot, owner of the current transaction
- mem_done  out  NUM_UNITS  one-hot, one-cycle completion pulse
- mem_error  out  NUM_UNITS  one-cycle pulse with mem_done on an illegal op or index
- read_data  out  vector_data_t  broadcast; valid with mem_done, held until the next completion
- busy  out  1  high when not in IDLE

Behaviour:
- Reset:
  - mem_grant, mem_done, mem_error, busy and read_data = 0.
  - State = IDLE; rr_ptr = 0; latency counter = 0.
  - Register file contents are not reset.
  - Reset mid-transaction aborts it; no store is committed.
- FSM IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Candidates are units with mem_request = 1.
  - Pick the first candidate at or after rr_ptr, with wrap-around.
  - At the edge: latch the winner's op, index and write_data; set mem_grant[winner]; counter = MEM_LATENCY-1; go to ACCESS.
  - rr_ptr = winner+1 mod NUM_UNITS.
  - No request: stay in IDLE.
- ACCESS:
  - Decrement the counter each cycle.
  - At counter == 0, execute at the edge and go to DONE:
    - Load or compute: read_data <= mem[idx].
    - Store: mem[idx] <= latched write_data; read_data unchanged.
    - Illegal op (any value other than 0001/0010/0100) or idx >= VEC_ENTRIES: no memory access; read_data <= 0; set error flag.
- DONE:
  - mem_done[winner] = 1 and mem_error[winner] = error flag, for exactly this cycle; mem_grant stays high.
  - Next edge: clear grant, done and error; go to IDLE.
- Latency: request first seen in IDLE at edge N -> mem_done high in cycle N+1+MEM_LATENCY.
- Back-to-back: requests seen in the DONE cycle are not arbitrated. The requester drops mem_request on the mem_done edge, so the next arbitration is the IDLE cycle that follows.
- Request deasserted mid-transaction: transaction still completes and a store commits. Inputs are latched, so later changes to op, index or data are ignored.
- Fairness: with all units requesting continuously, grants go 0,1,2,3,0...
- Worst-case wait for any unit: NUM_UNITS-1 transactions.
- read_data is a single registered vector; no per-unit copy.

Optional Feature:
- Macro: VEC_MEM_ARB_STATS_EN.
- When defined:
  - Adds output grant_count, NUM_UNITS x 16.
  - One per-unit counter increments on entering ACCESS for that unit; saturates at 16'hFFFF.
  - Cleared by reset.
- When undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared accel_pkg (existing):
  - vector_data_t, VECTOR_DEPTH, VECTOR_WIDTH.
  - New mem_op_t enum: MEM_LOAD=4'b0001, MEM_STORE=4'b0010, MEM_COMP=4'b0100.
  - arb_state_t enum (IDLE, ACCESS, DONE).
- Sub-module rr_arbiter:
  - Parameter N; inputs req[N] and ptr; outputs one-hot grant and any.
  - Purely combinational.
  - Instantiated once; the register file stays in the top module.

Test Plan:
- Store then load:
  - Unit 1 stores a distinct value per lane (lane i = i+1) to index 5, op 0010; then loads index 5, op 0001.
  - mem_done[1] at request-edge+3 (MEM_LATENCY=2); the load returns the same vector on read_data; mem_error = 0.
- Contention:
  - All four units request loads in the same cycle from IDLE, rr_ptr = 0.
  - Grant order 0,1,2,3; each mem_done exactly 4 cycles apart; mem_grant always one-hot.
- Illegal op:
  - Unit 2 issues op 4'b1000.
  - mem_done[2] and mem_error[2] pulse together; read_data = 0; memory unchanged, verified by a subsequent load.
- Abort by reset:
  - Unit 0 stores to index 3; rst_n pulled low during ACCESS, then released.
  - All outputs 0; a later load of index 3 returns the pre-store value.
- Dropped request:
  - Unit 3 starts a store to index 7 and deasserts mem_request in ACCESS.
  - mem_done[3] still pulses; index 7 holds the new data.
- Stats (VEC_MEM_ARB_STATS_EN defined):
  - Unit 0 completes 3 transactions -> grant_count[0] = 3, others = 0.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared accelerator types: vector payload, memory op codes, arbiter states.
package accel_pkg;

    localparam int unsigned VECTOR_DEPTH = 4;
    localparam int unsigned VECTOR_WIDTH = 16;
    localparam int unsigned OP_W         = 4;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned STAT_W       = 16;

    typedef logic [VECTOR_DEPTH-1:0][VECTOR_WIDTH-1:0] vector_data_t;

    typedef enum logic [OP_W-1:0] {
        MEM_LOAD  = 4'b0001,
        MEM_STORE = 4'b0010,
        MEM_COMP  = 4'b0100
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

    // Request captured from the winning unit at arbitration time.
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [IDX_W-1:0] idx;
        vector_data_t     data;
    } mem_req_t;

endpackage

// File: rtl/vec_mem_arbiter_if.sv
// Unit-side bus of the vector-memory arbiter.
// grant_count exists only when VEC_MEM_ARB_STATS_EN is defined.
interface vec_mem_arbiter_if #(
    parameter int unsigned NUM_UNITS = 4
) ();

    logic [NUM_UNITS-1:0]                        mem_request;
    logic [NUM_UNITS-1:0][accel_pkg::OP_W-1:0]   mem_op_type;
    logic [NUM_UNITS-1:0][accel_pkg::IDX_W-1:0]  vec_index;
    accel_pkg::vector_data_t [NUM_UNITS-1:0]     write_data;
    logic [NUM_UNITS-1:0]                        mem_grant;
    logic [NUM_UNITS-1:0]                        mem_done;
    logic [NUM_UNITS-1:0]                        mem_error;
    accel_pkg::vector_data_t                     read_data;
    logic                                        busy;
`ifdef VEC_MEM_ARB_STATS_EN
    logic [NUM_UNITS-1:0][accel_pkg::STAT_W-1:0] grant_count;

    modport master (
        output mem_request, mem_op_type, vec_index, write_data,
        input  mem_grant, mem_done, mem_error, read_data, busy, grant_count
    );
    modport slave (
        input  mem_request, mem_op_type, vec_index, write_data,
        output mem_grant, mem_done, mem_error, read_data, busy, grant_count
    );
`else
    modport master (
        output mem_request, mem_op_type, vec_index, write_data,
        input  mem_grant, mem_done, mem_error, read_data, busy
    );
    modport slave (
        input  mem_request, mem_op_type, vec_index, write_data,
        output mem_grant, mem_done, mem_error, read_data, busy
    );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          any
);

    logic          found;
    logic [PW-1:0] j;

    always_comb begin
        grant = '0;
        found = 1'b0;
        j     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j = PW'((32'(ptr) + i) % N);
            if (!found && req[j]) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/vec_mem_arbiter.sv
// Round-robin server for a shared vector register file (load/store/compute fetch).
// Define VEC_MEM_ARB_STATS_EN to add saturating per-unit grant counters.
module vec_mem_arbiter
    import accel_pkg::*;
#(
    parameter int unsigned NUM_UNITS   = 4,
    parameter int unsigned VEC_ENTRIES = 16,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    vec_mem_arbiter_if.slave  bus
);

    localparam int unsigned UIDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned EIDX_W = (VEC_ENTRIES > 1) ? $clog2(VEC_ENTRIES) : 1;
    localparam int unsigned CNT_W  = 4;

    arb_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [UIDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    mem_req_t              req_q, req_d;
    logic [NUM_UNITS-1:0]  grant_q, grant_d;
    logic [NUM_UNITS-1:0]  done_q, done_d;
    logic [NUM_UNITS-1:0]  error_q, error_d;
    vector_data_t          rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  mem_we;

    logic [NUM_UNITS-1:0]  arb_grant;
    logic                  arb_any;
    logic [UIDX_W-1:0]     win_c;
    logic                  op_ok, idx_ok;

    vector_data_t          mem [VEC_ENTRIES];

    rr_arbiter #(.N(NUM_UNITS)) u_rr (
        .req   (bus.mem_request),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .any   (arb_any)
    );

    // One-hot grant to index.
    always_comb begin
        win_c = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (arb_grant[i]) win_c = UIDX_W'(i);
        end
    end

    assign op_ok  = (req_q.op == MEM_LOAD) || (req_q.op == MEM_STORE) || (req_q.op == MEM_COMP);
    assign idx_ok = 32'(req_q.idx) < VEC_ENTRIES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            req_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            error_q  <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            req_q    <= req_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            error_q  <= error_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        req_d    = req_q;
        grant_d  = grant_q;
        done_d   = done_q;
        error_d  = error_q;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        mem_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d    = ACCESS;
                    cnt_d      = CNT_W'(MEM_LATENCY - 1);
                    rr_ptr_d   = UIDX_W'((32'(win_c) + 1) % NUM_UNITS);
                    req_d.op   = bus.mem_op_type[win_c];
                    req_d.idx  = bus.vec_index[win_c];
                    req_d.data = bus.write_data[win_c];
                    grant_d    = arb_grant;
                    busy_d     = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    done_d  = grant_q;
                    if (!op_ok || !idx_ok) begin
                        error_d = grant_q;
                        rdata_d = '0;
                    end else if (req_q.op == MEM_STORE) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[req_q.idx[EIDX_W-1:0]];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                done_d  = '0;
                error_d = '0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register file is deliberately not reset; reset keeps mem_we low so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (mem_we) mem[req_q.idx[EIDX_W-1:0]] <= req_q.data;
    end

    assign bus.mem_grant = grant_q;
    assign bus.mem_done  = done_q;
    assign bus.mem_error = error_q;
    assign bus.read_data = rdata_q;
    assign bus.busy      = busy_q;

`ifdef VEC_MEM_ARB_STATS_EN
    logic [NUM_UNITS-1:0][STAT_W-1:0] grant_cnt_q;

    // Counts ACCESS entries per unit, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
        end else if (state_q == IDLE && arb_any && grant_cnt_q[win_c] != '1) begin
            grant_cnt_q[win_c] <= grant_cnt_q[win_c] + STAT_W'(1);
        end
    end

    assign bus.grant_count = grant_cnt_q;
`endif

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Self-checking bench for vec_mem_arbiter against a transaction-level model.
module tb_vec_mem_arbiter;
    import accel_pkg::*;

    localparam int NU = 4;
    localparam int L  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vec_mem_arbiter_if #(.NUM_UNITS(NU)) bus ();

    vec_mem_arbiter #(.NUM_UNITS(NU), .VEC_ENTRIES(16), .MEM_LATENCY(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           errors = 0;
    int           checks = 0;
    vector_data_t ref_mem [16];
    vector_data_t model_rd;
    int           model_ptr;

    int           b_order [NU];
    int           b_tdone [NU];
    vector_data_t b_rd    [NU];
    logic [3:0]   b_idx   [NU];
    int           b_n;
    logic         b_hot;

    function automatic vector_data_t rand_vec();
        vector_data_t v;
        for (int i = 0; i < int'(VECTOR_DEPTH); i++) v[i] = VECTOR_WIDTH'($urandom);
        return v;
    endfunction

    task automatic clear_inputs();
        bus.mem_request = '0;
        bus.mem_op_type = '0;
        bus.vec_index   = '0;
        bus.write_data  = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_rd  = '0;
        model_ptr = 0;
    endtask

    // Drives one request from unit u and waits (bounded) for its completion.
    task automatic do_txn(input int u, input logic [3:0] op, input logic [3:0] idx,
                          input vector_data_t wd, output int lat, output logic err,
                          output vector_data_t rd, output logic own_ok);
        logic [NU-1:0] oh;
        logic          seen;
        oh = '0;
        oh[u] = 1'b1;
        @(negedge clk);
        bus.mem_op_type[u] = op;
        bus.vec_index[u]   = idx;
        bus.write_data[u]  = wd;
        bus.mem_request[u] = 1'b1;
        lat = 0; err = 1'b0; rd = '0; own_ok = 1'b1; seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.mem_grant != '0 && bus.mem_grant != oh) own_ok = 1'b0;
            if (bus.mem_done != '0) begin
                seen = 1'b1;
                err  = bus.mem_error[u];
                rd   = bus.read_data;
                if (bus.mem_done != oh || bus.mem_grant != oh) own_ok = 1'b0;
            end
        end
        bus.mem_request[u] = 1'b0;
        if (!seen) lat = -1;
    endtask

    // Requests loads from every unit in mask at once; records completion order.
    task automatic run_batch(input logic [NU-1:0] mask);
        int cyc;
        int want;
        @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            if (mask[u]) begin
                b_idx[u]           = 4'($urandom);
                bus.vec_index[u]   = b_idx[u];
                bus.mem_op_type[u] = ($urandom_range(0, 1) == 0) ? 4'(MEM_LOAD) : 4'(MEM_COMP);
                bus.mem_request[u] = 1'b1;
            end
        end
        want  = $countones(mask);
        b_n   = 0;
        b_hot = 1'b1;
        cyc   = 0;
        while (b_n < want && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (!$onehot0(bus.mem_grant) || !$onehot0(bus.mem_done)) b_hot = 1'b0;
            for (int u = 0; u < NU; u++) begin
                if (bus.mem_done[u] && b_n < NU) begin
                    b_order[b_n] = u;
                    b_tdone[b_n] = cyc;
                    b_rd[b_n]    = bus.read_data;
                    b_n++;
                    bus.mem_request[u] = 1'b0;
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_grant !== '0) begin errors++; $display("FAIL reset_grant: got %b want 0", bus.mem_grant); end
        checks++; if (bus.mem_done !== '0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.mem_done); end
        checks++; if (bus.mem_error !== '0) begin errors++; $display("FAIL reset_error: got %b want 0", bus.mem_error); end
        checks++; if (bus.read_data !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.read_data); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        rst_n = 1'b1;
        model_rd  = '0;
        model_ptr = 0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_init();
        int lat; logic err; vector_data_t rd, wd; logic ok;
        for (int i = 0; i < 16; i++) begin
            wd = rand_vec();
            do_txn($urandom_range(0, NU-1), 4'(MEM_STORE), 4'(i), wd, lat, err, rd, ok);
            ref_mem[i] = wd;
            checks++; if (lat !== L+1 || err !== 1'b0 || !ok) begin errors++; $display("FAIL init_store[%0d]: lat=%0d err=%b own=%b want lat=%0d err=0 own=1", i, lat, err, ok, L+1); end
            checks++; if (rd !== model_rd) begin errors++; $display("FAIL init_rdata[%0d]: got %h want %h", i, rd, model_rd); end
        end
    endtask

    task automatic test_store_load();
        int lat; logic err; vector_data_t rd, pat; logic ok;
        for (int i = 0; i < int'(VECTOR_DEPTH); i++) pat[i] = VECTOR_WIDTH'(i + 1);
        do_txn(1, 4'(MEM_STORE), 4'd5, pat, lat, err, rd, ok);
        ref_mem[5] = pat;
        checks++; if (lat !== L+1) begin errors++; $display("FAIL store_latency: got %0d want %0d", lat, L+1); end
        checks++; if (err !== 1'b0 || !ok) begin errors++; $display("FAIL store_flags: err=%b own=%b want err=0 own=1", err, ok); end
        checks++; if (rd !== model_rd) begin errors++; $display("FAIL store_rdata_held: got %h want %h", rd, model_rd); end
        do_txn(1, 4'(MEM_LOAD), 4'd5, rand_vec(), lat, err, rd, ok);
        model_rd = ref_mem[5];
        checks++; if (lat !== L+1) begin errors++; $display("FAIL load_latency: got %0d want %0d", lat, L+1); end
        checks++; if (rd !== model_rd) begin errors++; $display("FAIL load_rdata: got %h want %h", rd, model_rd); end
        checks++; if (err !== 1'b0 || !ok) begin errors++; $display("FAIL load_flags: err=%b own=%b want err=0 own=1", err, ok); end
    endtask

    task automatic test_illegal();
        int lat; logic err; vector_data_t rd; logic ok;
        do_txn(2, 4'b1000, 4'd4, rand_vec(), lat, err, rd, ok);
        model_rd = '0;
        checks++; if (err !== 1'b1 || lat !== L+1 || !ok) begin errors++; $display("FAIL illegal_flags: err=%b lat=%0d own=%b want err=1 lat=%0d own=1", err, lat, ok, L+1); end
        checks++; if (rd !== '0) begin errors++; $display("FAIL illegal_rdata: got %h want 0", rd); end
        do_txn(2, 4'(MEM_LOAD), 4'd4, rand_vec(), lat, err, rd, ok);
        model_rd = ref_mem[4];
        checks++; if (rd !== model_rd || err !== 1'b0) begin errors++; $display("FAIL illegal_mem_intact: got %h err=%b want %h err=0", rd, err, model_rd); end
    endtask

    task automatic test_dropped();
        int cyc; logic seen; vector_data_t wd, rd; int lat; logic err, ok;
        wd = rand_vec();
        @(negedge clk);
        bus.mem_op_type[3] = 4'(MEM_STORE);
        bus.vec_index[3]   = 4'd7;
        bus.write_data[3]  = wd;
        bus.mem_request[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_request[3] = 1'b0;
        bus.vec_index[3]   = 4'd8;
        bus.write_data[3]  = ~wd;
        bus.mem_op_type[3] = 4'(MEM_LOAD);
        cyc = 1; seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (bus.mem_done[3]) seen = 1'b1;
            else begin @(posedge clk); cyc++; @(negedge clk); end
        end
        ref_mem[7] = wd;
        checks++; if (!seen || cyc !== L+1) begin errors++; $display("FAIL dropped_done: seen=%b cyc=%0d want seen=1 cyc=%0d", seen, cyc, L+1); end
        checks++; if (bus.read_data !== model_rd) begin errors++; $display("FAIL dropped_rdata_held: got %h want %h", bus.read_data, model_rd); end
        clear_inputs();
        do_txn(0, 4'(MEM_LOAD), 4'd7, rand_vec(), lat, err, rd, ok);
        model_rd = ref_mem[7];
        checks++; if (rd !== model_rd) begin errors++; $display("FAIL dropped_commit: got %h want %h", rd, model_rd); end
        do_txn(0, 4'(MEM_COMP), 4'd8, rand_vec(), lat, err, rd, ok);
        model_rd = ref_mem[8];
        checks++; if (rd !== model_rd) begin errors++; $display("FAIL dropped_latched_idx: got %h want %h", rd, model_rd); end
    endtask

    task automatic test_abort();
        int lat; logic err; vector_data_t rd; logic ok;
        @(negedge clk);
        bus.mem_op_type[0] = 4'(MEM_STORE);
        bus.vec_index[0]   = 4'd3;
        bus.write_data[0]  = ~ref_mem[3];
        bus.mem_request[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b want 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.mem_grant, bus.mem_done, bus.mem_error, bus.busy} !== '0) begin errors++; $display("FAIL abort_outputs: grant=%b done=%b err=%b busy=%b want all 0", bus.mem_grant, bus.mem_done, bus.mem_error, bus.busy); end
        checks++; if (bus.read_data !== '0) begin errors++; $display("FAIL abort_rdata: got %h want 0", bus.read_data); end
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_rd  = '0;
        model_ptr = 0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.mem_done !== '0) begin errors++; $display("FAIL abort_quiet: busy=%b done=%b want 0", bus.busy, bus.mem_done); end
        do_txn(0, 4'(MEM_LOAD), 4'd3, rand_vec(), lat, err, rd, ok);
        model_rd = ref_mem[3];
        checks++; if (rd !== model_rd) begin errors++; $display("FAIL abort_no_commit: got %h want %h", rd, model_rd); end
    endtask

    task automatic test_contention();
        logic [NU-1:0] mask;
        int exp_order [$];
        apply_reset();
        for (int round = 0; round < 4; round++) begin
            mask = (round == 0) ? 4'hF : 4'($urandom_range(1, 15));
            exp_order.delete();
            for (int i = 0; i < NU; i++) begin
                if (mask[(model_ptr + i) % NU]) exp_order.push_back((model_ptr + i) % NU);
            end
            run_batch(mask);
            checks++; if (b_n !== exp_order.size()) begin errors++; $display("FAIL cont_count[%0d]: got %0d want %0d", round, b_n, exp_order.size()); end
            checks++; if (!b_hot) begin errors++; $display("FAIL cont_onehot[%0d]: got not-one-hot want one-hot", round); end
            for (int k = 0; k < exp_order.size() && k < b_n; k++) begin
                checks++; if (b_order[k] !== exp_order[k]) begin errors++; $display("FAIL cont_order[%0d][%0d]: got %0d want %0d", round, k, b_order[k], exp_order[k]); end
                checks++; if (b_rd[k] !== ref_mem[b_idx[exp_order[k]]]) begin errors++; $display("FAIL cont_rdata[%0d][%0d]: got %h want %h", round, k, b_rd[k], ref_mem[b_idx[exp_order[k]]]); end
                if (k == 0) begin
                    checks++; if (b_tdone[0] !== L+1) begin errors++; $display("FAIL cont_first_lat[%0d]: got %0d want %0d", round, b_tdone[0], L+1); end
                end else begin
                    checks++; if (b_tdone[k] - b_tdone[k-1] !== L+2) begin errors++; $display("FAIL cont_gap[%0d][%0d]: got %0d want %0d", round, k, b_tdone[k] - b_tdone[k-1], L+2); end
                end
            end
            model_ptr = (exp_order[exp_order.size()-1] + 1) % NU;
            model_rd  = ref_mem[b_idx[exp_order[exp_order.size()-1]]];
        end
    endtask

    task automatic test_random();
        int lat; logic err; vector_data_t rd, wd, exp_rd; logic ok;
        int u, r; logic [3:0] op, idx; logic exp_err;
        for (int t = 0; t < 40; t++) begin
            u   = $urandom_range(0, NU-1);
            idx = 4'($urandom);
            wd  = rand_vec();
            r   = $urandom_range(0, 3);
            if (r == 0) op = 4'(MEM_LOAD);
            else if (r == 1) op = 4'(MEM_STORE);
            else if (r == 2) op = 4'(MEM_COMP);
            else begin
                op = 4'($urandom);
                while (op == 4'b0001 || op == 4'b0010 || op == 4'b0100) op = 4'($urandom);
            end
            exp_err = 1'b0;
            if (op == 4'b0001 || op == 4'b0100) model_rd = ref_mem[idx];
            else if (op == 4'b0010) ref_mem[idx] = wd;
            else begin model_rd = '0; exp_err = 1'b1; end
            exp_rd = model_rd;
            do_txn(u, op, idx, wd, lat, err, rd, ok);
            checks++; if (rd !== exp_rd || err !== exp_err || lat !== L+1 || !ok) begin errors++; $display("FAIL rand[%0d] u=%0d op=%b idx=%0d: rd=%h err=%b lat=%0d own=%b want rd=%h err=%b lat=%0d own=1", t, u, op, idx, rd, err, lat, ok, exp_rd, exp_err, L+1); end
        end
    endtask

`ifdef VEC_MEM_ARB_STATS_EN
    task automatic test_stats();
        int lat; logic err; vector_data_t rd; logic ok;
        apply_reset();
        checks++; if (bus.grant_count !== '0) begin errors++; $display("FAIL stats_reset: got %h want 0", bus.grant_count); end
        for (int i = 0; i < 3; i++) do_txn(0, 4'(MEM_LOAD), 4'(i), rand_vec(), lat, err, rd, ok);
        checks++; if (bus.grant_count[0] !== 16'd3) begin errors++; $display("FAIL stats_unit0: got %0d want 3", bus.grant_count[0]); end
        for (int u = 1; u < NU; u++) begin
            checks++; if (bus.grant_count[u] !== 16'd0) begin errors++; $display("FAIL stats_unit%0d: got %0d want 0", u, bus.grant_count[u]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_init();
        test_store_load();
        test_illegal();
        test_dropped();
        test_abort();
        test_contention();
        test_random();
`ifdef VEC_MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1, "watchdog");
    end

endmodule
